// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared shifter state type and sizing helpers for serializer_lanes
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    // Number of data beats needed to carry one word.
    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // Beat counter width; never narrower than one bit, even for a single-beat word.
    function automatic int cnt_w(input int nb);
        return (nb <= 1) ? 1 : $clog2(nb);
    endfunction

endpackage

// File: rtl/serializer_lanes_if.sv
// rtl/serializer_lanes_if.sv - word-in / beat-out handshake bundle for serializer_lanes
interface serializer_lanes_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 1
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [LANES-1:0] data_o;
    logic             valid_o;
    logic             frame_o;
    logic             last_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        input  frame_o,
        input  last_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output data_o,
        output valid_o,
        output frame_o,
        output last_o
    );
endinterface

// File: rtl/serializer_shift.sv
// rtl/serializer_shift.sv - shift register, beat counter and registered beat outputs; SERIALIZER_PARITY_EN appends a per-lane parity beat
module serializer_shift
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             idle,
    output logic             final_beat,
    output logic [LANES-1:0] data_o,
    output logic             valid_o,
    output logic             frame_o,
    output logic             last_o
);

    localparam int BEATS = beats(WIDTH, LANES);
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = BEATS + 1;
`else
    localparam int NB = BEATS;
`endif
    localparam int CW = cnt_w(NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(BEATS - 1);
`endif

    shift_state_e     state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [LANES-1:0] data_n;
    logic             valid_n, frame_n, last_n;
`ifdef SERIALIZER_PARITY_EN
    logic [LANES-1:0] par, par_n;
`endif

    // Beat that leaves the word first, given the configured order.
    function automatic logic [LANES-1:0] head(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WIDTH-1 -: LANES];
        end else begin
            return w[LANES-1:0];
        end
    endfunction

    // Drop the beat just taken so the next one sits at the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << LANES;
        end else begin
            return w >> LANES;
        end
    endfunction

    assign idle       = (state == IDLE);
    assign final_beat = (state == SHIFT) && (cnt == CNT_LAST);

    // Next beat selection: a fresh load, the next beat of the current word, or going idle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        data_n  = data_o;
`ifdef SERIALIZER_PARITY_EN
        par_n   = par;
`endif
        if (load) begin
            state_n = SHIFT;
            cnt_n   = '0;
            data_n  = head(load_data);
            sreg_n  = advance(load_data);
`ifdef SERIALIZER_PARITY_EN
            par_n   = head(load_data);
`endif
        end else if ((state == SHIFT) && (cnt != CNT_LAST)) begin
            cnt_n = cnt + CW'(1);
`ifdef SERIALIZER_PARITY_EN
            if (cnt == DATA_LAST) begin
                data_n = par;
            end else begin
                data_n = head(sreg);
                sreg_n = advance(sreg);
                par_n  = par ^ head(sreg);
            end
`else
            data_n = head(sreg);
            sreg_n = advance(sreg);
`endif
        end else begin
            state_n = IDLE;
            cnt_n   = '0;
            data_n  = '0;
        end
        valid_n = (state_n == SHIFT);
        frame_n = (state_n == SHIFT) && (cnt_n == '0);
        last_n  = (state_n == SHIFT) && (cnt_n == CNT_LAST);
    end

    // State, counter, shift data and beat outputs all update together on the clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            frame_o <= 1'b0;
            last_o  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par     <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            data_o  <= data_n;
            valid_o <= valid_n;
            frame_o <= frame_n;
            last_o  <= last_n;
`ifdef SERIALIZER_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule

// File: rtl/serializer_lanes.sv
// rtl/serializer_lanes.sv - parallel-to-serial lane converter top: hold register, handshake, bypass; SERIALIZER_PARITY_EN adds parity beat
module serializer_lanes
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset,
    serializer_lanes_if.slave  bus
);

    if ((WIDTH % LANES) != 0) begin : g_bad_width
        $error("serializer_lanes: WIDTH must be a multiple of LANES");
    end

    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic             accept;
    logic             bypass;
    logic             to_hold;
    logic             hold_to_shift;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             idle;
    logic             final_beat;

    // A full hold register is the only thing that stalls the source.
    assign bus.ready_o = !hold_valid && !reset;

    // Route an accepted word straight into the shifter when it is free next cycle, else park it.
    always_comb begin
        accept        = bus.valid_i && bus.ready_o;
        bypass        = accept && (idle || final_beat);
        to_hold       = accept && !bypass;
        hold_to_shift = final_beat && hold_valid;
        load          = bypass || hold_to_shift;
        load_data     = hold_valid ? hold : bus.data_i;
    end

    // Hold register fills when the shifter is busy and drains on the shifter's final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (to_hold) begin
            hold       <= bus.data_i;
            hold_valid <= 1'b1;
        end else if (hold_to_shift) begin
            hold_valid <= 1'b0;
        end
    end

    serializer_shift #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .idle       (idle),
        .final_beat (final_beat),
        .data_o     (bus.data_o),
        .valid_o    (bus.valid_o),
        .frame_o    (bus.frame_o),
        .last_o     (bus.last_o)
    );

endmodule

// File: tb/tb_serializer_lanes.sv
// tb/tb_serializer_lanes.sv - four serializer_lanes configurations against a beat-queue reference model
module tb_serializer_lanes;

    localparam int N = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int lanes_of [N] = '{4, 1, 4, 16};
    int msb_of   [N] = '{1, 1, 0, 1};

    logic        vld  [N] = '{default: 1'b0};
    logic [15:0] din  [N] = '{default: 16'h0};
    logic        rdy  [N];
    logic        vout [N];
    logic        fout [N];
    logic        lout [N];
    logic [15:0] dout [N];

    int total = 0;
    int bad = 0;

    // reference model: expected beat stream per DUT, {valid,last,frame,data}
    logic [18:0] mq  [N][64];
    int          mh  [N] = '{default: 0};
    int          mt  [N] = '{default: 0};
    logic [18:0] cur [N] = '{default: 19'h0};
    int          acc [N] = '{default: 0};
    int          dxf [N] = '{default: 0};
    logic [63:0] cap [N] = '{default: 64'h0};

    serializer_lanes_if #(.WIDTH(16), .LANES(4))  if0 ();
    serializer_lanes_if #(.WIDTH(16), .LANES(1))  if1 ();
    serializer_lanes_if #(.WIDTH(16), .LANES(4))  if2 ();
    serializer_lanes_if #(.WIDTH(16), .LANES(16)) if3 ();

    serializer_lanes #(.WIDTH(16), .LANES(4),  .MSB_FIRST(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    serializer_lanes #(.WIDTH(16), .LANES(1),  .MSB_FIRST(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    serializer_lanes #(.WIDTH(16), .LANES(4),  .MSB_FIRST(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    serializer_lanes #(.WIDTH(16), .LANES(16), .MSB_FIRST(1)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if0.valid_i = vld[0];  assign if0.data_i = din[0];
    assign if1.valid_i = vld[1];  assign if1.data_i = din[1];
    assign if2.valid_i = vld[2];  assign if2.data_i = din[2];
    assign if3.valid_i = vld[3];  assign if3.data_i = din[3];

    assign rdy[0] = if0.ready_o;  assign vout[0] = if0.valid_o;  assign fout[0] = if0.frame_o;  assign lout[0] = if0.last_o;
    assign rdy[1] = if1.ready_o;  assign vout[1] = if1.valid_o;  assign fout[1] = if1.frame_o;  assign lout[1] = if1.last_o;
    assign rdy[2] = if2.ready_o;  assign vout[2] = if2.valid_o;  assign fout[2] = if2.frame_o;  assign lout[2] = if2.last_o;
    assign rdy[3] = if3.ready_o;  assign vout[3] = if3.valid_o;  assign fout[3] = if3.frame_o;  assign lout[3] = if3.last_o;
    assign dout[0] = {12'h0, if0.data_o};
    assign dout[1] = {15'h0, if1.data_o};
    assign dout[2] = {12'h0, if2.data_o};
    assign dout[3] = if3.data_o;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic int nb_of(input int i);
        return 16 / lanes_of[i] + PAR;
    endfunction

    function automatic int qlen(input int i);
        return mt[i] - mh[i];
    endfunction

    // beat number b in transmission order, taken straight from the word by arithmetic
    function automatic logic [15:0] beat_val(input int i, input logic [15:0] w, input int b);
        int          bts  = 16 / lanes_of[i];
        int          bi   = (msb_of[i] != 0) ? (bts - 1 - b) : b;
        logic [31:0] mask = (32'd1 << lanes_of[i]) - 32'd1;
        logic [31:0] sh   = {16'h0, w} >> (bi * lanes_of[i]);
        return 16'(sh & mask);
    endfunction

    function automatic logic [15:0] pack(input int i, input logic [15:0] w);
        logic [15:0] r = 16'h0;
        for (int b = 0; b < 16 / lanes_of[i]; b++) r = (r << lanes_of[i]) | beat_val(i, w, b);
        return r;
    endfunction

    task automatic push_word(input int i, input logic [15:0] w);
        int          bts = 16 / lanes_of[i];
        int          nb  = bts + PAR;
        logic [15:0] p   = 16'h0;
        logic [15:0] v;
        for (int b = 0; b < bts; b++) begin
            v = beat_val(i, w, b);
            p = p ^ v;
            mq[i][mt[i] % 64] = {1'b1, (b == nb - 1), (b == 0), v};
            mt[i]++;
        end
        if (PAR != 0) begin
            mq[i][mt[i] % 64] = {1'b1, 1'b1, 1'b0, p};
            mt[i]++;
        end
    endtask

    // model step at each rising edge: accept into the beat queue, then present the next beat
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (reset) begin
                    mh[i] = 0;
                    mt[i] = 0;
                    cur[i] = 19'h0;
                end else begin
                    if (vld[i] && (qlen(i) < nb_of(i))) begin
                        push_word(i, din[i]);
                        acc[i]++;
                    end
                    if (qlen(i) > 0) begin
                        cur[i] = mq[i][mh[i] % 64];
                        mh[i]++;
                    end else begin
                        cur[i] = 19'h0;
                    end
                end
            end
        end
    end

    // compare every output of every DUT on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk("ready", i, 64'(rdy[i]), 64'(!reset && (qlen(i) < nb_of(i))));
                chk("valid", i, 64'(vout[i]), 64'(cur[i][18]));
                chk("last",  i, 64'(lout[i]), 64'(cur[i][17]));
                chk("frame", i, 64'(fout[i]), 64'(cur[i][16]));
                chk("data",  i, 64'(dout[i]), 64'(cur[i][15:0]));
                if (vld[i] && rdy[i]) dxf[i]++;
                if (vout[i]) cap[i] = (cap[i] << lanes_of[i]) | 64'(dout[i]);
            end
        end
    end

    function automatic logic [63:0] low(input logic [63:0] v, input int bits);
        return (bits >= 64) ? v : (v & ((64'd1 << bits) - 64'd1));
    endfunction

    logic [15:0] b2b [3] = '{16'h1234, 16'hABCD, 16'h0F0F};

    initial begin
        int k;
        int budget;
        int start;
        int x0;

        // the model's beat ordering pinned against hand-computed values
        chk("pin_msb_l4", 0, 64'(pack(0, 16'h1234)), 64'h1234);
        chk("pin_msb_l1", 1, 64'(pack(1, 16'hA5C3)), 64'hA5C3);
        chk("pin_lsb_l4", 2, 64'(pack(2, 16'h1234)), 64'h4321);
        chk("pin_l16",    3, 64'(pack(3, 16'hBEEF)), 64'hBEEF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_valid", i, 64'(vout[i]), 64'h0);
            chk("rst_ready", i, 64'(rdy[i]), 64'h0);
            chk("rst_data",  i, 64'(dout[i]), 64'h0);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        // one word into every configuration at once
        vld = '{1'b1, 1'b1, 1'b1, 1'b1};
        din = '{16'h1234, 16'hA5C3, 16'h1234, 16'hBEEF};
        @(posedge clk); #2;
        vld = '{default: 1'b0};
        @(negedge clk);
        chk("lat_frame0", 0, 64'(fout[0]), 64'h1);
        chk("lat_data0",  0, 64'(dout[0]), 64'h1);
        chk("lat_data1",  1, 64'(dout[1]), 64'h1);
        chk("lat_data2",  2, 64'(dout[2]), 64'h4);
        chk("lat_data3",  3, 64'(dout[3]), 64'hBEEF);
        chk("l16_frame",  3, 64'(fout[3]), 64'h1);
        chk("l16_last",   3, 64'(lout[3]), 64'(PAR == 0));
        repeat (20) @(posedge clk);
        #2;
        chk("word_l4_msb", 0, low(cap[0], 16 + 4 * PAR), (PAR != 0) ? 64'h12344 : 64'h1234);
        chk("word_l1_msb", 1, low(cap[1], 16 + PAR),     (PAR != 0) ? 64'h14B86 : 64'hA5C3);
        chk("word_l4_lsb", 2, low(cap[2], 16 + 4 * PAR), (PAR != 0) ? 64'h43214 : 64'h4321);
        chk("word_l16",    3, low(cap[3], 16 + 16 * PAR), (PAR != 0) ? 64'hBEEFBEEF : 64'hBEEF);

        // back-to-back stream with valid held high
        k = 0;
        budget = 0;
        start = acc[0];
        x0 = dxf[0];
        vld[0] = 1'b1;
        din[0] = b2b[0];
        while ((k < 3) && (budget < 100)) begin
            @(posedge clk); #2;
            budget++;
            if ((acc[0] - start) > k) begin
                k++;
                if (k < 3) din[0] = b2b[k];
            end
        end
        vld[0] = 1'b0;
        chk("b2b_accepted", 0, 64'(k), 64'd3);
        repeat (16) @(posedge clk);
        #2;
        chk("b2b_stream", 0, low(cap[0], 48 + 12 * PAR), (PAR != 0) ? 64'h12344ABCD00F0F0 : 64'h1234ABCD0F0F);
        chk("b2b_xfers", 0, 64'(dxf[0] - x0), 64'd3);

        // reset while beat 2 of a word is on the output
        vld[0] = 1'b1;
        din[0] = 16'h1234;
        @(posedge clk); #2;
        vld[0] = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_beat2", 0, 64'(dout[0]), 64'h2);
        @(negedge clk);
        chk("trunc_valid", 0, 64'(vout[0]), 64'h0);
        chk("trunc_data",  0, 64'(dout[0]), 64'h0);
        chk("trunc_ready", 0, 64'(rdy[0]), 64'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 0, 64'(rdy[0]), 64'h1);
        @(posedge clk); #2;
        vld[0] = 1'b1;
        din[0] = 16'h5678;
        @(posedge clk); #2;
        vld[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("post_rst_word", 0, low(cap[0], 16 + 4 * PAR), (PAR != 0) ? 64'h5678C : 64'h5678);

        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                din[i] = 16'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            @(posedge clk); #2;
        end
        reset = 1'b0;
        vld = '{default: 1'b0};
        repeat (40) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializer_lanes.md
# serializer_lanes

Parametrised single-clock parallel-to-serial converter. Accepts WIDTH-bit words over a valid/ready handshake and emits them as LANES-bit beats, with selectable bit order and zero-gap back-to-back streaming. It replaces the divided-clock serializer path: no derived clocks, and everything runs on clk. It sits between the parallel datapath and the serial line driver.

## Interface
- WIDTH, 16, input word width; WIDTH % LANES == 0 is required, checked at elaboration.
- LANES, 1, output lanes per beat (1, 2, 4, 8 …).
- MSB_FIRST, 1, 1 sends the most significant beat first; 0 sends the least significant beat first.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_i  in  WIDTH  parallel word.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept a word this cycle.
- data_o  out  LANES  current beat.
- valid_o  out  1  data_o carries a beat.
- frame_o  out  1  current beat is the first beat of a word.
- last_o  out  1  current beat is the final beat of a word.

## Operation
- BEATS = WIDTH/LANES data beats per word.
- Beat b is data_i[(b+1)*LANES-1 : b*LANES]; lane k of data_o carries bit k of the beat.
- MSB_FIRST=1 sends beats in the order BEATS-1 down to 0; MSB_FIRST=0 sends 0 up to BEATS-1.
- Storage: one shift register (shifter) plus a one-word holding register (hold).
- Shifter states: IDLE (no word) and SHIFT (beat counter cnt from 0 to NB-1). NB = BEATS, or BEATS+1 with parity enabled.
- Transfer: a word is accepted on a rising edge where valid_i && ready_o.
- ready_o = !hold_valid && !reset. There is no combinational path from valid_i to ready_o.
- On acceptance:
  - If the shifter is IDLE, or it is on its final beat and hold is empty, the word loads straight into the shifter (bypass).
  - Otherwise the word is written into hold.
- When the shifter is on its final beat and hold is valid, hold moves into the shifter and hold_valid clears.
- SHIFT with no successor word returns to IDLE after the final beat.
- Outputs are registered. In IDLE: data_o=0, valid_o=0, frame_o=0, last_o=0.
- frame_o=1 only when cnt==0. last_o=1 only when cnt==NB-1.
- There is no output backpressure. Once a word starts, all of its beats are emitted on consecutive cycles.
- If valid_i drops while ready_o is low, nothing happens. data_i is sampled only at a transfer.

## Timing
- Latency: from the acceptance edge to the first beat on data_o is 1 cycle (bypass path).
- Throughput: one word per NB cycles, sustained, with no idle beat between words when the source keeps valid_i high.
- ready_o falls the cycle after a word is written into hold. It rises the cycle after hold empties into the shifter.
- Reset:
  - While reset=1 at a rising edge: the shifter goes to IDLE, hold_valid=0, and all outputs are 0.
  - ready_o is 0 while reset is high.
  - A word in flight is truncated. No last_o is produced for it.
- Boundary: with LANES==WIDTH, BEATS=1, so frame_o and last_o are both high on every beat. The counter is still 1 bit wide.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - One extra beat follows the data beats of each word (NB = BEATS+1).
  - Lane k of the parity beat = XOR of bit k across all data beats (even parity per lane).
  - last_o marks the parity beat.
- Not defined:
  - NB = BEATS and no parity logic is present.
  - last_o marks the final data beat.

## Structure
- serializer_pkg holds:
  - function beats(WIDTH, LANES);
  - function cnt_w(nb) = max(1, $clog2(nb));
  - the shifter state enum (IDLE, SHIFT).
- Sub-module serializer_shift contains the shift register, beat counter, parity accumulator and output registers.
- The top level contains the hold register, handshake and bypass selection.

## Test plan
- WIDTH=16, LANES=1, MSB_FIRST=1, single word 0xA5C3 → data_o over 16 consecutive cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. frame_o on beat 1, last_o on beat 16, then valid_o=0.
- WIDTH=16, LANES=4, word 0x1234 → MSB_FIRST=1 gives beats 0x1,0x2,0x3,0x4; MSB_FIRST=0 gives 0x4,0x3,0x2,0x1. Each word starts 1 cycle after acceptance.
- Back-to-back: LANES=4, words 0x1234, 0xABCD, 0x0F0F with valid_i held high → 12 contiguous beats, no gap. ready_o low while hold is full. Exactly three transfers occur.
- Reset mid-word: assert reset on beat 2 of 0x1234 → the next cycle has valid_o=0, data_o=0, ready_o=0. After release, ready_o=1 and a fresh word 0x5678 emits 0x5,0x6,0x7,0x8 cleanly.
- LANES=WIDTH=16, word 0xBEEF → a single beat 0xBEEF with frame_o=last_o=1.
- SERIALIZER_PARITY_EN:
  - LANES=4, 0x1234 → beats 0x1,0x2,0x3,0x4, then parity 0x4 with last_o.
  - LANES=1, 0xA5C3 → 17th beat is 0.
